// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive buffer: entry layout and pending-commit FSM states.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_ENT_W  = 10;
  localparam int ENT_PAR     = 8;
  localparam int ENT_FRM     = 9;
  localparam int DLY_CNT_W   = 12;

  typedef enum logic {
    P_IDLE = 1'b0,
    P_WAIT = 1'b1
  } pend_state_e;
endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x 10 storage with a synchronous write port and a registered synchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [UART_ENT_W-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [UART_ENT_W-1:0] rd_data_o
);
  logic [UART_ENT_W-1:0] mem_q [DEPTH];
  logic [UART_ENT_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read sees the pre-write contents when both ports hit the same slot (full FIFO).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: holds each byte until its stop bit ends, then commits byte+flags to a FIFO.
// Optional macro UART_RX_FIFO_DROP_ERR_EN discards bytes carrying a parity or frame error.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int COMMIT_DLY = 880
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [UART_DATA_W-1:0] RX_DATA,
  input  logic                   RX_DATA_RDY,
  input  logic                   PARITY_ERR,
  input  logic                   FRM_ERR,
  input  logic                   RD_EN,
  output logic [UART_DATA_W-1:0] RD_DATA,
  output logic                   RD_FRM_ERR,
  output logic                   RD_PAR_ERR,
  output logic                   RD_VALID,
  output logic                   EMPTY,
  output logic                   FULL,
  output logic [ADDR_W:0]        COUNT,
  output logic                   OVERFLOW,
  input  logic                   OVF_CLR,
  output pend_state_e            PEND_STATE
);
  pend_state_e           state_q, state_d;
  logic [ENT_FRM-1:0]    hold_q, hold_d;
  logic [DLY_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  commit;
  logic                  wr_req, wr_ok, rd_ok;
  logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d, rd_valid_q;
  logic [UART_ENT_W-1:0] wr_entry, rd_entry;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= P_IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new byte arriving while one is pending forces the old one out early so nothing is lost.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      P_IDLE: begin
        if (RX_DATA_RDY) begin
          hold_d  = {PARITY_ERR, RX_DATA};
          cnt_d   = DLY_CNT_W'(COMMIT_DLY - 1);
          state_d = P_WAIT;
        end
      end
      P_WAIT: begin
        if (RX_DATA_RDY) begin
          commit = 1'b1;
          hold_d = {PARITY_ERR, RX_DATA};
          cnt_d  = DLY_CNT_W'(COMMIT_DLY - 1);
        end else if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = P_IDLE;
        end else begin
          cnt_d = cnt_q - DLY_CNT_W'(1);
        end
      end
      default: state_d = P_IDLE;
    endcase
  end

  assign wr_entry = {FRM_ERR, hold_q};

`ifdef UART_RX_FIFO_DROP_ERR_EN
  assign wr_req = commit && !FRM_ERR && !hold_q[ENT_PAR];
`else
  assign wr_req = commit;
`endif

  // Read handshake: RD_EN is a request sampled every clock; it is honoured only when the FIFO
  // is non-empty, and the head entry then appears on RD_* with RD_VALID=1 one clock later.
  assign EMPTY = (wr_ptr_q == rd_ptr_q);
  assign FULL  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign COUNT = wr_ptr_q - rd_ptr_q;
  assign rd_ok = RD_EN && !EMPTY;
  assign wr_ok = wr_req && (!FULL || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
    if (OVF_CLR)              ovf_d = 1'b0;
    else if (wr_req && !wr_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_ok;
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .wr_en_i   (wr_ok),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (wr_entry),
    .rd_en_i   (rd_ok),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (rd_entry)
  );

  assign RD_DATA    = rd_entry[UART_DATA_W-1:0];
`ifdef UART_RX_FIFO_DROP_ERR_EN
  assign RD_FRM_ERR = 1'b0;
  assign RD_PAR_ERR = 1'b0;
`else
  assign RD_FRM_ERR = rd_entry[ENT_FRM];
  assign RD_PAR_ERR = rd_entry[ENT_PAR];
`endif
  assign RD_VALID   = rd_valid_q;
  assign OVERFLOW   = ovf_q;
  assign PEND_STATE = state_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with COMMIT_DLY=20, DEPTH=4.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH      = 4;
  localparam int ADDR_W     = 2;
  localparam int COMMIT_DLY = 20;
`ifdef UART_RX_FIFO_DROP_ERR_EN
  localparam bit DROP_ERR = 1'b1;
`else
  localparam bit DROP_ERR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_data = '0;
  logic             rx_data_rdy = 1'b0;
  logic             parity_err = 1'b0;
  logic             frm_err = 1'b0;
  logic             rd_en = 1'b0;
  logic [7:0]       rd_data;
  logic             rd_frm_err, rd_par_err, rd_valid;
  logic             empty, full, overflow;
  logic [ADDR_W:0]  count;
  logic             ovf_clr = 1'b0;
  pend_state_e      pend_state;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_fifo #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .COMMIT_DLY (COMMIT_DLY)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .RX_DATA     (rx_data),
    .RX_DATA_RDY (rx_data_rdy),
    .PARITY_ERR  (parity_err),
    .FRM_ERR     (frm_err),
    .RD_EN       (rd_en),
    .RD_DATA     (rd_data),
    .RD_FRM_ERR  (rd_frm_err),
    .RD_PAR_ERR  (rd_par_err),
    .RD_VALID    (rd_valid),
    .EMPTY       (empty),
    .FULL        (full),
    .COUNT       (count),
    .OVERFLOW    (overflow),
    .OVF_CLR     (ovf_clr),
    .PEND_STATE  (pend_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic par);
    rx_data     = d;
    parity_err  = par;
    rx_data_rdy = 1'b1;
    tick();
    rx_data_rdy = 1'b0;
    parity_err  = 1'b0;
  endtask

  task automatic commit_byte(input logic [7:0] d);
    send_byte(d, 1'b0);
    tick(COMMIT_DLY);
  endtask

  task automatic read_expect(input string tag, input logic [7:0] d,
                             input logic par, input logic frm);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check({tag, ".valid"}, 32'(rd_valid), 32'd1);
    check({tag, ".data"},  32'(rd_data),  32'(d));
    check({tag, ".par"},   32'(rd_par_err), 32'(par && !DROP_ERR));
    check({tag, ".frm"},   32'(rd_frm_err), 32'(frm && !DROP_ERR));
  endtask

  initial begin
    tick(2);
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.full",  32'(full),  32'd0);
    check("rst.count", 32'(count), 32'd0);
    check("rst.valid", 32'(rd_valid), 32'd0);
    check("rst.ovf",   32'(overflow), 32'd0);
    check("rst.data",  32'(rd_data),  32'd0);
    rst_n = 1'b1;
    tick(2);

    // Basic byte: commit lands exactly COMMIT_DLY clocks after the ready pulse.
    send_byte(8'h5A, 1'b0);
    tick(COMMIT_DLY - 1);
    check("t1.empty_before", 32'(empty), 32'd1);
    tick();
    check("t1.empty_after", 32'(empty), 32'd0);
    check("t1.count", 32'(count), 32'd1);
    read_expect("t1.rd", 8'h5A, 1'b0, 1'b0);
    check("t1.empty_drained", 32'(empty), 32'd1);
    tick();
    check("t1.valid_pulse", 32'(rd_valid), 32'd0);
    check("t1.data_hold", 32'(rd_data), 32'h5A);

    // Parity error at capture, frame error raised mid-wait.
    send_byte(8'hC3, 1'b1);
    tick(9);
    frm_err = 1'b1;
    tick(COMMIT_DLY - 9);
    frm_err = 1'b0;
    if (DROP_ERR) begin
      check("t2.drop_empty", 32'(empty), 32'd1);
      check("t2.drop_count", 32'(count), 32'd0);
      check("t2.drop_ovf",   32'(overflow), 32'd0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("t2.drop_rdvalid", 32'(rd_valid), 32'd0);
    end else begin
      check("t2.count", 32'(count), 32'd1);
      read_expect("t2.rd", 8'hC3, 1'b1, 1'b1);
    end

    // Back-to-back bytes: second ready forces the first out immediately.
    send_byte(8'h11, 1'b0);
    tick(4);
    send_byte(8'h22, 1'b0);
    check("t3.early_commit", 32'(count), 32'd1);
    tick(COMMIT_DLY);
    check("t3.count", 32'(count), 32'd2);
    read_expect("t3.rd0", 8'h11, 1'b0, 1'b0);
    read_expect("t3.rd1", 8'h22, 1'b0, 1'b0);

    // Overflow: five commits into a four-deep FIFO.
    for (int i = 1; i <= 4; i++) commit_byte(8'(i));
    check("t4.full", 32'(full), 32'd1);
    check("t4.count", 32'(count), 32'd4);
    check("t4.ovf_pre", 32'(overflow), 32'd0);
    commit_byte(8'h05);
    check("t4.ovf", 32'(overflow), 32'd1);
    check("t4.count_post", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) read_expect("t4.rd", 8'(i), 1'b0, 1'b0);
    check("t4.empty", 32'(empty), 32'd1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t4.rd_empty_valid", 32'(rd_valid), 32'd0);
    check("t4.rd_empty_hold", 32'(rd_data), 32'h04);
    check("t4.rd_empty_count", 32'(count), 32'd0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4.ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with a read and a commit in the same cycle.
    for (int i = 0; i < 4; i++) commit_byte(8'hA0 + 8'(i));
    check("t5.full", 32'(full), 32'd1);
    send_byte(8'h99, 1'b0);
    tick(COMMIT_DLY - 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t5.count", 32'(count), 32'd4);
    check("t5.ovf", 32'(overflow), 32'd0);
    check("t5.valid", 32'(rd_valid), 32'd1);
    check("t5.data", 32'(rd_data), 32'hA0);
    for (int i = 1; i < 4; i++) read_expect("t5.rd", 8'hA0 + 8'(i), 1'b0, 1'b0);
    read_expect("t5.rd_last", 8'h99, 1'b0, 1'b0);
    check("t5.empty", 32'(empty), 32'd1);

    // Reset during the wait discards the pending byte.
    send_byte(8'h3C, 1'b0);
    tick(5);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    check("t6.state", 32'(pend_state), 32'(P_IDLE));
    tick(COMMIT_DLY + 5);
    check("t6.empty", 32'(empty), 32'd1);
    check("t6.count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
